led_frame_sequencer: RTL and testbench

- Consumer of the 10 Hz divider's one-cycle tick.
- On each accepted tick it renders one "chase" frame: exactly NUM_LEDS 24-bit GRB pixel words, streamed over a valid/ready handshake to the WS2812B bit serializer downstream.
- The lit position advances once per completed frame, so the animation rate is set by the tick rate.

---
 rtl/led_frame_sequencer_if.sv | 22 ++
 rtl/led_frame_sequencer.sv | 149 ++++++++++++++
 tb/tb_led_frame_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_frame_sequencer_if.sv
// Pixel stream between the frame sequencer and the WS2812B bit serializer.
// A word moves on every cycle where pix_valid && pix_ready.
interface led_frame_sequencer_if;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        pix_last;
    logic        pix_ready;

    modport master (
        output pix_valid,
        output pix_data,
        output pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  pix_last,
        output pix_ready
    );
endinterface

// File: rtl/led_frame_sequencer.sv
// Chase-animation frame sequencer. Each accepted tick streams one frame of
// NUM_LEDS GRB words with a single lit LED at position `step`; the lit
// position advances once per completed frame.
// Optional build macro LED_SEQ_BOUNCE_EN: step ping-pongs between the two ends
// of the strip instead of wrapping back to 0.
module led_frame_sequencer #(
    parameter int          NUM_LEDS = 8,
    parameter int          IDX_W    = 8,
    parameter logic [23:0] FG_COLOR = 24'h10_00_00,
    parameter logic [23:0] BG_COLOR = 24'h00_00_00
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    tick,
    led_frame_sequencer_if.master   pix,
    output logic                    frame_done,
    output logic                    overrun,
    output logic                    busy,
    output logic [IDX_W-1:0]        step
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);
    localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [IDX_W-1:0] step_nxt;
    logic             pend;
    logic             pend_nxt;
    logic             tick_ok;
    logic             xfer;
`ifdef LED_SEQ_BOUNCE_EN
    logic             dir;      // 0 = counting up, 1 = counting down
    logic             dir_nxt;
`endif

    assign tick_ok = tick && enable;
    // pix_valid is exactly "in SEND", so the transfer condition can be formed
    // from state directly without reading back the output.
    assign xfer    = (state == SEND) && pix.pix_ready;

    // Next-state, counters, one-deep tick queue and all outputs.
    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        step_nxt       = step;
        pend_nxt       = pend;
`ifdef LED_SEQ_BOUNCE_EN
        dir_nxt        = dir;
`endif
        busy           = 1'b0;
        frame_done     = 1'b0;
        overrun        = 1'b0;
        pix.pix_valid  = 1'b0;
        pix.pix_data   = '0;
        pix.pix_last   = 1'b0;

        case (state)
            IDLE: begin
                if (tick_ok || pend) begin
                    state_nxt = SEND;
                    idx_nxt   = '0;
                    // A fresh tick arriving while a queued one is consumed
                    // takes its place in the queue rather than being lost.
                    pend_nxt  = pend && tick_ok;
                end
            end
            SEND: begin
                busy          = 1'b1;
                pix.pix_valid = 1'b1;
                pix.pix_data  = (idx == step) ? FG_COLOR : BG_COLOR;
                pix.pix_last  = (idx == LAST_IDX);
                if (xfer) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt = idx + ONE;
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
`ifdef LED_SEQ_BOUNCE_EN
                if (!dir) begin
                    if (step == LAST_IDX) begin
                        step_nxt = step - ONE;
                        dir_nxt  = 1'b1;
                    end else begin
                        step_nxt = step + ONE;
                    end
                end else begin
                    if (step == '0) begin
                        step_nxt = step + ONE;
                        dir_nxt  = 1'b0;
                    end else begin
                        step_nxt = step - ONE;
                    end
                end
`else
                step_nxt = (step == LAST_IDX) ? '0 : step + ONE;
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Ticks outside IDLE fill the one-deep queue, or are dropped if full.
        if ((state != IDLE) && tick_ok) begin
            if (!pend) begin
                pend_nxt = 1'b1;
            end else begin
                overrun = 1'b1;
            end
        end
    end

    // State and counter registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
            step  <= '0;
            pend  <= 1'b0;
`ifdef LED_SEQ_BOUNCE_EN
            dir   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            step  <= step_nxt;
            pend  <= pend_nxt;
`ifdef LED_SEQ_BOUNCE_EN
            dir   <= dir_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed bench for led_frame_sequencer with a 4-LED strip.
module tb_led_frame_sequencer;

    localparam int          N     = 4;
    localparam logic [23:0] FG    = 24'h100000;
    localparam logic [23:0] BG    = 24'h000000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       tick = 1'b0;
    logic       frame_done;
    logic       overrun;
    logic       busy;
    logic [7:0] step;

    led_frame_sequencer_if pix_if ();

    led_frame_sequencer #(
        .NUM_LEDS (N),
        .IDX_W    (8),
        .FG_COLOR (FG),
        .BG_COLOR (BG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .tick       (tick),
        .pix        (pix_if),
        .frame_done (frame_done),
        .overrun    (overrun),
        .busy       (busy),
        .step       (step)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [23:0] cap_data [N];
    logic        cap_last [N];
    int          cap_n;
    bit          done_seen;

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        tick             = 1'b0;
        enable           = 1'b1;
        pix_if.pix_ready = 1'b0;
        reset            = 1'b0;
        step_clk();
        step_clk();
        reset            = 1'b1;
        step_clk();
    endtask

    // Drives one tick from IDLE and captures the frame; leaves the DUT in IDLE.
    task automatic do_frame();
        cap_n            = 0;
        done_seen        = 1'b0;
        enable           = 1'b1;
        pix_if.pix_ready = 1'b1;
        tick             = 1'b1;
        step_clk();
        tick             = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (frame_done) begin
                done_seen = 1'b1;
                break;
            end
            if (pix_if.pix_valid && cap_n < N) begin
                cap_data[cap_n] = pix_if.pix_data;
                cap_last[cap_n] = pix_if.pix_last;
                cap_n++;
            end
            step_clk();
        end
        step_clk();
    endtask

    task automatic test_reset();
        pix_if.pix_ready = 1'b1;
        #1;
        n_checks++;
        if ({pix_if.pix_valid, pix_if.pix_last, frame_done, overrun, busy} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000",
                     {pix_if.pix_valid, pix_if.pix_last, frame_done, overrun, busy});
        else n_pass++;
        n_checks++;
        if (pix_if.pix_data !== 24'h0) $display("FAIL reset_data: got %h want 000000", pix_if.pix_data);
        else n_pass++;
        n_checks++;
        if (step !== 8'd0) $display("FAIL reset_step: got %0d want 0", step);
        else n_pass++;
        step_clk();
        reset = 1'b1;
        step_clk();
        n_checks++;
        if (pix_if.pix_valid !== 1'b0) $display("FAIL idle_after_reset: pix_valid=%b want 0", pix_if.pix_valid);
        else n_pass++;
    endtask

    task automatic test_single_frame();
        logic [23:0] exp_w [N];
        exp_w[0] = FG; exp_w[1] = BG; exp_w[2] = BG; exp_w[3] = BG;
        enable           = 1'b1;
        pix_if.pix_ready = 1'b1;
        tick             = 1'b1;
        step_clk();
        tick             = 1'b0;
        n_checks++;
        if (pix_if.pix_valid !== 1'b1 || busy !== 1'b1)
            $display("FAIL latency: pix_valid=%b busy=%b want 1 1", pix_if.pix_valid, busy);
        else n_pass++;
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (pix_if.pix_valid !== 1'b1 || pix_if.pix_data !== exp_w[i] ||
                pix_if.pix_last !== (i == N - 1))
                $display("FAIL word%0d: valid=%b data=%h last=%b want 1 %h %b",
                         i, pix_if.pix_valid, pix_if.pix_data, pix_if.pix_last,
                         exp_w[i], (i == N - 1));
            else n_pass++;
            step_clk();
        end
        n_checks++;
        if (frame_done !== 1'b1 || pix_if.pix_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL done_cycle: frame_done=%b valid=%b busy=%b want 1 0 0",
                     frame_done, pix_if.pix_valid, busy);
        else n_pass++;
        step_clk();
        n_checks++;
        if (step !== 8'd1 || frame_done !== 1'b0)
            $display("FAIL step_after_frame: step=%0d frame_done=%b want 1 0", step, frame_done);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
`ifdef LED_SEQ_BOUNCE_EN
        int exp_lit [7] = '{0, 1, 2, 3, 2, 1, 0};
        int exp_step_end = 1;
`else
        int exp_lit [7] = '{0, 1, 2, 3, 0, 1, 2};
        int exp_step_end = 3;
`endif
        int lit;
        int fg_cnt;
        bit last_ok;
        apply_reset();
        for (int f = 0; f < 7; f++) begin
            do_frame();
            n_checks++;
            if (cap_n != N || !done_seen)
                $display("FAIL frame%0d_len: words=%0d done=%b want %0d 1", f, cap_n, done_seen, N);
            else n_pass++;
            lit = -1;
            fg_cnt = 0;
            last_ok = 1'b1;
            for (int i = 0; i < cap_n; i++) begin
                if (cap_data[i] === FG) begin
                    lit = i;
                    fg_cnt++;
                end else if (cap_data[i] !== BG) begin
                    fg_cnt = 99;
                end
                if (cap_last[i] !== (i == N - 1)) last_ok = 1'b0;
            end
            if (fg_cnt != 1) lit = -1;
            n_checks++;
            if (lit != exp_lit[f]) $display("FAIL frame%0d_lit: got %0d want %0d", f, lit, exp_lit[f]);
            else n_pass++;
            n_checks++;
            if (!last_ok) $display("FAIL frame%0d_last: pix_last misplaced, want only word %0d", f, N - 1);
            else n_pass++;
        end
        n_checks++;
        if (step !== 8'(exp_step_end)) $display("FAIL b2b_step_end: got %0d want %0d", step, exp_step_end);
        else n_pass++;
    endtask

    task automatic test_stall();
        bit stall_ok;
        apply_reset();
        pix_if.pix_ready = 1'b1;
        tick             = 1'b1;
        step_clk();
        tick             = 1'b0;
        step_clk();
        step_clk();
        pix_if.pix_ready = 1'b0;
        stall_ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step_clk();
            if (pix_if.pix_valid !== 1'b1 || pix_if.pix_data !== BG ||
                pix_if.pix_last !== 1'b0 || busy !== 1'b1)
                stall_ok = 1'b0;
        end
        n_checks++;
        if (!stall_ok)
            $display("FAIL stall_hold: valid=%b data=%h last=%b busy=%b want 1 000000 0 1",
                     pix_if.pix_valid, pix_if.pix_data, pix_if.pix_last, busy);
        else n_pass++;
        pix_if.pix_ready = 1'b1;
        step_clk();
        n_checks++;
        if (pix_if.pix_valid !== 1'b1 || pix_if.pix_last !== 1'b1)
            $display("FAIL stall_resume: valid=%b last=%b want 1 1", pix_if.pix_valid, pix_if.pix_last);
        else n_pass++;
        step_clk();
        n_checks++;
        if (frame_done !== 1'b1) $display("FAIL stall_done: frame_done=%b want 1", frame_done);
        else n_pass++;
        step_clk();
    endtask

    task automatic test_overrun();
        bit extra_valid;
        apply_reset();
        pix_if.pix_ready = 1'b1;
        tick             = 1'b1;
        step_clk();
        tick             = 1'b0;
        pix_if.pix_ready = 1'b0;
        step_clk();
        tick = 1'b1;
        #1;
        n_checks++;
        if (overrun !== 1'b0) $display("FAIL ovr_first_tick: overrun=%b want 0", overrun);
        else n_pass++;
        step_clk();
        n_checks++;
        if (overrun !== 1'b1) $display("FAIL ovr_second_tick: overrun=%b want 1", overrun);
        else n_pass++;
        step_clk();
        tick = 1'b0;
        #1;
        n_checks++;
        if (overrun !== 1'b0) $display("FAIL ovr_single_pulse: overrun=%b want 0", overrun);
        else n_pass++;
        pix_if.pix_ready = 1'b1;
        for (int c = 0; c < 20 && !frame_done; c++) step_clk();
        n_checks++;
        if (frame_done !== 1'b1) $display("FAIL ovr_frame1_done: timed out, frame_done=%b want 1", frame_done);
        else n_pass++;
        step_clk();
        n_checks++;
        if (pix_if.pix_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL ovr_idle_gap: valid=%b busy=%b want 0 0", pix_if.pix_valid, busy);
        else n_pass++;
        step_clk();
        n_checks++;
        if (pix_if.pix_valid !== 1'b1 || pix_if.pix_data !== BG)
            $display("FAIL ovr_extra_start: valid=%b data=%h want 1 000000", pix_if.pix_valid, pix_if.pix_data);
        else n_pass++;
        for (int c = 0; c < 20 && !frame_done; c++) step_clk();
        n_checks++;
        if (frame_done !== 1'b1) $display("FAIL ovr_frame2_done: timed out, frame_done=%b want 1", frame_done);
        else n_pass++;
        extra_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step_clk();
            if (pix_if.pix_valid !== 1'b0) extra_valid = 1'b1;
        end
        n_checks++;
        if (extra_valid) $display("FAIL ovr_only_one_extra: saw a third frame, want none");
        else n_pass++;
        n_checks++;
        if (step !== 8'd2) $display("FAIL ovr_step: got %0d want 2", step);
        else n_pass++;
    endtask

    task automatic test_disable();
        bit saw_valid;
        apply_reset();
        pix_if.pix_ready = 1'b1;
        enable           = 1'b0;
        tick             = 1'b1;
        step_clk();
        tick             = 1'b0;
        saw_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (pix_if.pix_valid !== 1'b0) saw_valid = 1'b1;
            step_clk();
        end
        n_checks++;
        if (saw_valid) $display("FAIL disable_no_frame: pix_valid rose, want 0");
        else n_pass++;
        enable = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step_clk();
            if (pix_if.pix_valid !== 1'b0) saw_valid = 1'b1;
        end
        n_checks++;
        if (saw_valid) $display("FAIL disable_no_pend: frame started after enable, want none");
        else n_pass++;
        n_checks++;
        if (step !== 8'd0) $display("FAIL disable_step: got %0d want 0", step);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        apply_reset();
        do_frame();
        pix_if.pix_ready = 1'b1;
        tick             = 1'b1;
        step_clk();
        tick             = 1'b0;
        step_clk();
        n_checks++;
        if (pix_if.pix_valid !== 1'b1 || pix_if.pix_data !== FG)
            $display("FAIL rst_mid_setup: valid=%b data=%h want 1 100000", pix_if.pix_valid, pix_if.pix_data);
        else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({pix_if.pix_valid, pix_if.pix_last, frame_done, overrun, busy} !== 5'b0 ||
            pix_if.pix_data !== 24'h0 || step !== 8'd0)
            $display("FAIL rst_mid_async: valid=%b last=%b done=%b ovr=%b busy=%b data=%h step=%0d want all 0",
                     pix_if.pix_valid, pix_if.pix_last, frame_done, overrun, busy, pix_if.pix_data, step);
        else n_pass++;
        step_clk();
        n_checks++;
        if (frame_done !== 1'b0) $display("FAIL rst_mid_no_done: frame_done=%b want 0", frame_done);
        else n_pass++;
        reset = 1'b1;
        step_clk();
        do_frame();
        n_checks++;
        if (cap_n != N || cap_data[0] !== FG || cap_data[1] !== BG)
            $display("FAIL rst_mid_restart: words=%0d w0=%h w1=%h want %0d 100000 000000",
                     cap_n, cap_data[0], cap_data[1], N);
        else n_pass++;
        n_checks++;
        if (step !== 8'd1) $display("FAIL rst_mid_step: got %0d want 1", step);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stall();
        test_overrun();
        test_disable();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, want finish before 200us");
        $fatal(1);
    end

endmodule
